register_file_mp: RTL and testbench

- Parametrised multi-port register file; successor to the fixed 32x32, 2-read/1-write register file in the CPU datapath.
- Generalised in data width, depth and read-port count; reads are registered, with a valid flag and write-first bypass.
- Storage is a plain array with no per-entry reset, so it maps to RAM. Contents are zeroed by a sequential init engine after reset or on CLEAR.

---
 rtl/register_file_mp_pkg.sv | 13 +
 rtl/register_file_mp_read_port.sv | 37 +++
 rtl/register_file_mp.sv | 92 +++++++++
 tb/tb_register_file_mp.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared defaults, FSM encoding and port-slice helper for register_file_mp.
package register_file_mp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic {INIT, RUN} state_e;

    function automatic int slice_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/register_file_mp_read_port.sv
// regfile_read_port: one registered read port with write-first bypass and optional zero-register masking.
// REG_FILE_ZERO_REG_EN makes address 0 always read as zero.
module regfile_read_port
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d, rdata;

    assign rdata = (wr_en_i && wr_addr_i == addr_i) ? wr_data_i : mem_data_i;

`ifdef REG_FILE_ZERO_REG_EN
    assign data_d = rd_en_i ? ((addr_i == '0) ? '0 : rdata) : data_q;
`else
    assign data_d = rd_en_i ? rdata : data_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) data_q <= '0;
        else         data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read/one-write register file with zeroing init engine.
// Define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    CLEAR,
    input  logic                                    READ,
    input  logic [slice_w(NUM_RD, ADDR_WIDTH)-1:0]  ADDR_R,
    output logic [slice_w(NUM_RD, DATA_WIDTH)-1:0]  DATA_R,
    output logic                                    RD_VALID,
    input  logic                                    WRITE,
    input  logic [ADDR_WIDTH-1:0]                   ADDR_W,
    input  logic [DATA_WIDTH-1:0]                   DATA_W,
    output logic                                    READY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  valid_q;
    logic                  run, rd_en, wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign run   = (state_q == RUN);
    assign rd_en = run & READ & ~CLEAR;
`ifdef REG_FILE_ZERO_REG_EN
    assign wr_en = run & WRITE & ~CLEAR & (ADDR_W != '0);
`else
    assign wr_en = run & WRITE & ~CLEAR;
`endif

    // The counter MSB rises exactly when the last entry has been cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (CLEAR) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (!run) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_d[ADDR_WIDTH] ? RUN : INIT;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= rd_en;
        end
    end

    // No reset on the array so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (!run)       mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
        else if (wr_en) mem[ADDR_W] <= DATA_W;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [DATA_WIDTH-1:0] port_q;
        regfile_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .clk_i      (CLK),
            .rst_ni     (RST),
            .rd_en_i    (rd_en),
            .addr_i     (ADDR_R[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_data_i (mem[ADDR_R[k*ADDR_WIDTH +: ADDR_WIDTH]]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (ADDR_W),
            .wr_data_i  (DATA_W),
            .data_o     (port_q)
        );
        assign DATA_R[k*DATA_WIDTH +: DATA_WIDTH] = valid_q ? port_q : 'z;
    end

    assign RD_VALID = valid_q;
    assign READY    = run;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for register_file_mp (2 ports, 32x32).
module tb_register_file_mp;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CLEAR = 1'b0;
    logic        READ = 1'b0;
    logic [9:0]  ADDR_R = '0;
    logic [63:0] DATA_R;
    logic        RD_VALID;
    logic        WRITE = 1'b0;
    logic [4:0]  ADDR_W = '0;
    logic [31:0] DATA_W = '0;
    logic        READY;

    int          tests = 0;
    int          fails = 0;
    bit          in_init = 1'b0;
    logic [63:0] sb[$];

    register_file_mp dut (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .READ(READ), .ADDR_R(ADDR_R),
        .DATA_R(DATA_R), .RD_VALID(RD_VALID), .WRITE(WRITE), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .READY(READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] fexp(input int i);
`ifdef REG_FILE_ZERO_REG_EN
        if (i == 0) return 32'h0;
`endif
        return 32'(i) + 32'h00414020;
    endfunction

    function automatic bit is_off(input logic [63:0] v);
        return (v === {64{1'bz}}) || (v === 64'h0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [4:0] aw, input logic [31:0] dw,
                        input logic r, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1, input logic clr);
        WRITE = w; ADDR_W = aw; DATA_W = dw;
        READ = r; ADDR_R = {a1, a0}; CLEAR = clr;
        if (r && !in_init) sb.push_back({e1, e0});
        @(posedge CLK);
        #1;
        WRITE = 0; READ = 0; CLEAR = 0;
    endtask

    task automatic wr(input logic [4:0] aw, input logic [31:0] dw);
        step(1, aw, dw, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] e0, input logic [31:0] e1);
        step(0, 0, 0, 1, a0, a1, e0, e1, 0);
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int  n = 0;
        bit  bad = 0;
        while (!READY && n < 100) begin
            if (RD_VALID) bad = 1;
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
        check({name, "_novalid"}, 64'(bad), 64'h0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (RST && RD_VALID) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid: got data %h with no read outstanding", DATA_R);
                    end else begin
                        check("read_data", DATA_R, sb.pop_front());
                    end
                end
            end
        join_none

        #1;
        check("rst_ready", 64'(READY), 64'h0);
        check("rst_valid", 64'(RD_VALID), 64'h0);
        check("rst_data_off", 64'(is_off(DATA_R)), 64'h1);
        #11 RST = 1'b1;
        wait_ready("init_len", 32);

        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) + 32'h00414020);
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), fexp(i), fexp(31 - i));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("valid_drop", 64'(RD_VALID), 64'h0);

        wr(5, 32'hAAAA0000);
        step(1, 5, 32'h12345678, 1, 5, 6, 32'h12345678, fexp(6), 0);
        rd(5, 6, 32'h12345678, fexp(6));
        rd(9, 9, fexp(9), fexp(9));

`ifdef REG_FILE_ZERO_REG_EN
        step(1, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0, 32'h0, 0);
        rd(0, 0, 32'h0, 32'h0);
`else
        step(1, 0, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        rd(0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
`endif

        step(1, 3, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1);
        check("clear_ready", 64'(READY), 64'h0);
        wait_ready("clear_len", 32);
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 32'h0, 32'h0);

        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        in_init = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 32'h55555555, 1, 1, 1, 0, 0, 0);
            check("init_rd_valid", 64'(RD_VALID), 64'h0);
        end
        in_init = 1'b0;
        wait_ready("init_access_len", 25);
        rd(1, 1, 32'h0, 32'h0);

        wr(2, 32'h00001234);
        rd(2, 2, 32'h00001234, 32'h00001234);
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        check("midrst_valid", 64'(RD_VALID), 64'h0);
        check("midrst_data_off", 64'(is_off(DATA_R)), 64'h1);
        check("midrst_ready", 64'(READY), 64'h0);
        #2 RST = 1'b1;
        wait_ready("midrst_len", 32);
        rd(2, 2, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
